// File: rtl/seq_lock_fsm.sv
// seq_lock_fsm: matches an input symbol stream against a DEPTH-entry key table.
// A full match pulses hit and bumps the wrapping match counter. A mismatch parks
// the block in LOCK until the unlock code is seen.
// Optional macro SEQ_TIMEOUT_EN: abandon TRACK after TIMEOUT consecutive idle cycles.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      symbol handshake (in_ready is low only in HIT)
//   in_data [W]            stream symbol
//   key_wr/key_idx/key_data key-table write port, honoured only in IDLE
//   unlock [W]             code that releases LOCK
//   out [Y]                count of completed matches
//   state [2]              IDLE=0 TRACK=1 HIT=2 LOCK=3
//   hit                    one-cycle pulse while in HIT
//   timeout                one-cycle pulse after a TRACK timeout (0 without the macro)
module seq_lock_fsm #(
    parameter int unsigned W       = 32,
    parameter int unsigned Y       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     key_wr,
    input  logic [$clog2(DEPTH)-1:0] key_idx,
    input  logic [W-1:0]             key_data,
    input  logic [W-1:0]             unlock,
    output logic [Y-1:0]             out,
    output logic [1:0]               state,
    output logic                     hit,
    output logic                     timeout
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HIT   = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t         cur_state, nxt_state;
    logic [IW-1:0]  idx, idx_nx;
    logic [W-1:0]   key [DEPTH];
    logic           accept;

    assign accept = in_valid && in_ready;
    assign state  = cur_state;

    // Key table; writes land at the edge, so a same-cycle compare sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) key[i] <= '0;
        end else if (key_wr && (cur_state == IDLE) && (32'(key_idx) < DEPTH)) begin
            key[key_idx] <= key_data;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [TW-1:0] timer, timer_nx;
    logic          timeout_nx;
`endif

    // Next-state logic.
    always_comb begin
        nxt_state = cur_state;
        idx_nx    = idx;
`ifdef SEQ_TIMEOUT_EN
        timer_nx   = '0;
        timeout_nx = 1'b0;
`endif
        case (cur_state)
            IDLE: begin
                if (accept) begin
                    if (in_data == key[0]) begin
                        idx_nx    = IW'(1);
                        nxt_state = TRACK;
                    end else begin
                        nxt_state = LOCK;
                    end
                end
            end
            TRACK: begin
                if (accept) begin
                    if (in_data == key[idx]) begin
                        if (idx == IW'(DEPTH - 1)) nxt_state = HIT;
                        else                       idx_nx    = idx + IW'(1);
                    end else begin
                        idx_nx    = '0;
                        nxt_state = LOCK;
                    end
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (timer == TW'(TIMEOUT - 1)) begin
                        idx_nx     = '0;
                        nxt_state  = IDLE;
                        timeout_nx = 1'b1;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
`endif
                end
            end
            HIT: begin
                idx_nx    = '0;
                nxt_state = IDLE;
            end
            LOCK: begin
                // Unlock only returns to IDLE; the same symbol never also starts a match.
                if (accept && (in_data == unlock)) begin
                    idx_nx    = '0;
                    nxt_state = IDLE;
                end
            end
            default: begin
                idx_nx    = '0;
                nxt_state = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            idx       <= '0;
            out       <= '0;
            hit       <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            cur_state <= nxt_state;
            idx       <= idx_nx;
            hit       <= (nxt_state == HIT);
            in_ready  <= (nxt_state != HIT);
            if (cur_state == HIT) out <= out + Y'(1);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Idle-cycle timer for TRACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            timer   <= timer_nx;
            timeout <= timeout_nx;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seq_lock_fsm.sv
// Directed self-checking bench for seq_lock_fsm (W=32, Y=2, DEPTH=4, TIMEOUT=3).
module tb_seq_lock_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        key_wr = 1'b0;
    logic [1:0]  key_idx = '0;
    logic [31:0] key_data = '0;
    logic [31:0] unlock = '0;
    logic [1:0]  out;
    logic [1:0]  state;
    logic        hit;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    seq_lock_fsm #(.W(32), .Y(2), .DEPTH(4), .TIMEOUT(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_wr(key_wr), .key_idx(key_idx), .key_data(key_data),
        .unlock(unlock), .out(out), .state(state), .hit(hit), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] sym);
        in_valid = 1'b1;
        in_data  = sym;
        step();
        in_valid = 1'b0;
    endtask

    task automatic write_key(input logic [1:0] i, input logic [31:0] v);
        key_wr   = 1'b1;
        key_idx  = i;
        key_data = v;
        step();
        key_wr   = 1'b0;
    endtask

    // Full sequence ending in HIT, then one cycle to leave HIT.
    task automatic run_seq(input logic [31:0] k0, input string tag, input logic [1:0] exp_out);
        send(k0);
        send(32'd7);
        send(32'd9);
        send(32'd3);
        check({tag, "_hit"}, 32'(hit), 32'd1);
        step();
        check({tag, "_out"}, 32'(out), 32'(exp_out));
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        write_key(2'd0, 32'd5);
        write_key(2'd1, 32'd7);
        write_key(2'd2, 32'd9);
        write_key(2'd3, 32'd3);
        unlock = 32'd9;

        // Basic match walk
        send(32'd5);  check("m_s1", 32'(state), 32'd1);
        send(32'd7);  check("m_s2", 32'(state), 32'd1);
        send(32'd9);  check("m_s3", 32'(state), 32'd1);
        send(32'd3);  check("m_hit_state", 32'(state), 32'd2);
        check("m_hit", 32'(hit), 32'd1);
        check("m_hit_ready", 32'(in_ready), 32'd0);
        check("m_hit_out", 32'(out), 32'd0);
        // Symbol offered during HIT must not be consumed
        send(32'd5);
        check("m_after_state", 32'(state), 32'd0);
        check("m_after_hit", 32'(hit), 32'd0);
        check("m_after_out", 32'(out), 32'd1);

        // Counter wrap with Y=2
        run_seq(32'd5, "w2", 2'd2);
        run_seq(32'd5, "w3", 2'd3);
        run_seq(32'd5, "w0", 2'd0);

        // Mismatch -> LOCK, unlock returns to IDLE
        send(32'd5);
        send(32'd8);  check("l_lock", 32'(state), 32'd3);
        send(32'd4);  check("l_stay", 32'(state), 32'd3);
        send(32'd9);  check("l_idle", 32'(state), 32'd0);
        check("l_out", 32'(out), 32'd0);

        // unlock == key[0]: exit goes to IDLE only
        unlock = 32'd5;
        send(32'd1);  check("u_lock", 32'(state), 32'd3);
        send(32'd5);  check("u_idle", 32'(state), 32'd0);
        unlock = 32'd9;

        // Key write dropped in TRACK, same-cycle IDLE write compares old key
        send(32'd5);
        write_key(2'd0, 32'd6);
        check("k_track", 32'(state), 32'd1);
        send(32'd7);
        send(32'd9);
        send(32'd3);
        check("k_hit", 32'(hit), 32'd1);
        step();
        check("k_out1", 32'(out), 32'd1);
        key_wr = 1'b1; key_idx = 2'd0; key_data = 32'd6;
        send(32'd5);
        key_wr = 1'b0;
        check("k_oldkey", 32'(state), 32'd1);
        send(32'd7);
        send(32'd9);
        send(32'd3);
        step();
        check("k_out2", 32'(out), 32'd2);
        send(32'd5);  check("k_newkey_lock", 32'(state), 32'd3);
        send(32'd9);
        run_seq(32'd6, "k6", 2'd3);

        // TRACK idle behaviour
        send(32'd6);
        step();
        step();
        check("t_mid_state", 32'(state), 32'd1);
        step();
`ifdef SEQ_TIMEOUT_EN
        check("t_state", 32'(state), 32'd0);
        check("t_pulse", 32'(timeout), 32'd1);
        step();
        check("t_pulse_end", 32'(timeout), 32'd0);
`else
        check("t_state", 32'(state), 32'd1);
        check("t_pulse", 32'(timeout), 32'd0);
`endif
        send(32'd1);
        send(32'd9);
        check("t_recover", 32'(state), 32'd0);
        check("t_out", 32'(out), 32'd3);

        // Reset mid-sequence clears state, counter and keys
        send(32'd6);
        send(32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("r_state", 32'(state), 32'd0);
        check("r_out", 32'(out), 32'd0);
        send(32'd0);
        send(32'd0);
        send(32'd0);
        send(32'd0);
        check("r_zero_hit", 32'(hit), 32'd1);
        step();
        check("r_zero_out", 32'(out), 32'd1);

        // Reset while in HIT does not count the match
        send(32'd0);
        send(32'd0);
        send(32'd0);
        send(32'd0);
        check("rh_state", 32'(state), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rh_out", 32'(out), 32'd0);
        check("rh_hit", 32'(hit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
